// File: rtl/pet_action_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// pet_action_scheduler_pkg
// Definitions shared by the action scheduler and the pet core FSM: the action
// command codes, the scheduler state encoding and small helper functions.
// No ports (package).
// ---------------------------------------------------------------------------
package pet_action_scheduler_pkg;

  typedef logic [2:0] act_code_t;

  localparam act_code_t ACT_NONE     = 3'd0;
  localparam act_code_t ACT_FEED     = 3'd1;
  localparam act_code_t ACT_HEAL     = 3'd2;
  localparam act_code_t ACT_CHANGE   = 3'd3;
  localparam act_code_t ACT_TEST_ON  = 3'd4;
  localparam act_code_t ACT_TEST_OFF = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_COOLDOWN = 2'd2
  } sched_state_t;

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A test request toggles the mode, so its code depends on the current mode.
  function automatic act_code_t test_code(input logic mode);
    return mode ? ACT_TEST_OFF : ACT_TEST_ON;
  endfunction

  function automatic logic is_test_code(input act_code_t code);
    return (code == ACT_TEST_ON) || (code == ACT_TEST_OFF);
  endfunction

endpackage

// File: rtl/pet_action_scheduler_if.sv
// ---------------------------------------------------------------------------
// pet_action_scheduler_if
// Valid/ack action command channel between the scheduler and the pet core.
//   action_valid : command present (scheduler -> core)
//   action_code  : command code, stable while valid (scheduler -> core)
//   action_ack   : core accepts the command (core -> scheduler)
// Modports: master = scheduler side, slave = pet core side.
// ---------------------------------------------------------------------------
interface pet_action_scheduler_if;
  import pet_action_scheduler_pkg::*;

  logic      action_valid;
  act_code_t action_code;
  logic      action_ack;

  modport master (
    output action_valid,
    output action_code,
    input  action_ack
  );

  modport slave (
    input  action_valid,
    input  action_code,
    output action_ack
  );

endinterface

// File: rtl/pet_action_scheduler_edge_latch.sv
// ---------------------------------------------------------------------------
// edge_latch
// Registers a debounced button level, detects its rising edge and holds a
// pending request bit until the arbiter grants it.
//   clk       : system clock
//   rst       : synchronous reset, active low
//   level_i   : debounced button level
//   clr_i     : grant of this request, clears the pending bit
//   pending_o : request waiting to be served
// ---------------------------------------------------------------------------
module edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  input  logic clr_i,
  output logic pending_o
);

  logic sample_q;
  logic pend_q;
  logic pend_d;
  logic rise;

  assign rise = level_i & ~sample_q;

  // Set wins over clear: a rise coinciding with the grant yields one more
  // request. Repeated rises while pending merge into the same bit.
  always_comb begin
    pend_d = (pend_q & ~clr_i) | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sample_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      sample_q <= level_i;
      pend_q   <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/pet_action_scheduler.sv
// ---------------------------------------------------------------------------
// pet_action_scheduler
// Turns debounced button levels into single, ordered action commands for the
// pet core: edge detection, pending latches, fixed-priority arbitration
// (TEST > HEAL > FEED > CHANGE), valid/ack handshake with timeout, a
// long-press test-mode toggle and a post-action cooldown.
//   clk         : system clock
//   rst         : synchronous reset, active low
//   feeding     : debounced feed button level
//   healing     : debounced heal button level
//   change      : debounced change-view button level
//   test_sig    : debounced test button level (long press toggles test mode)
//   act_if      : action command channel (master side)
//   test_mode   : current test-mode level
//   ack_timeout : one-cycle pulse when an action is dropped for lack of ack
//   busy        : high whenever the FSM is not in IDLE
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | waiting for a pending request; grants the highest one
// ST_WAIT_ACK | action_valid high, code held; waits for ack or timeout
// ST_COOLDOWN | ignores grants for COOLDOWN_CYCLES, then back to IDLE
// ---------------------------------------------------------------------------
module pet_action_scheduler
  import pet_action_scheduler_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 250_000_000,
  parameter int unsigned COOLDOWN_CYCLES = 25_000_000,
  parameter int unsigned ACK_TIMEOUT     = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     feeding,
  input  logic                     healing,
  input  logic                     change,
  input  logic                     test_sig,
  pet_action_scheduler_if.master   act_if,
  output logic                     test_mode,
  output logic                     ack_timeout,
  output logic                     busy
);

  localparam int unsigned HW      = cnt_width(HOLD_CYCLES);
  localparam int unsigned TMR_MAX = (ACK_TIMEOUT > COOLDOWN_CYCLES) ? ACK_TIMEOUT
                                                                    : COOLDOWN_CYCLES;
  localparam int unsigned TW      = cnt_width(TMR_MAX);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LOAD  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] COOL_LOAD = TW'(COOLDOWN_CYCLES - 1);

  sched_state_t  state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  act_code_t     code_q, code_d;
  logic          test_mode_q, test_mode_d;
  logic          tmo_q, tmo_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          hold_fired_q, hold_fired_d;
  logic          pend_test_q, pend_test_d;

  logic pend_feed, pend_heal, pend_change;
  logic clr_feed, clr_heal, clr_change, clr_test;
  logic hold_fire;

  edge_latch u_feed (
    .clk       (clk),
    .rst       (rst),
    .level_i   (feeding),
    .clr_i     (clr_feed),
    .pending_o (pend_feed)
  );

  edge_latch u_heal (
    .clk       (clk),
    .rst       (rst),
    .level_i   (healing),
    .clr_i     (clr_heal),
    .pending_o (pend_heal)
  );

  edge_latch u_change (
    .clk       (clk),
    .rst       (rst),
    .level_i   (change),
    .clr_i     (clr_change),
    .pending_o (pend_change)
  );

  // Long-press detector: the counter saturates at HOLD_LAST and the fired
  // flag blocks a second request until the button is released.
  assign hold_fire = test_sig && (hold_cnt_q == HOLD_LAST) && !hold_fired_q;

  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    hold_fired_d = hold_fired_q;
    if (!test_sig) begin
      hold_cnt_d   = '0;
      hold_fired_d = 1'b0;
    end else begin
      if (hold_cnt_q != HOLD_LAST) begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
      if (hold_fire) begin
        hold_fired_d = 1'b1;
      end
    end
    pend_test_d = (pend_test_q & ~clr_test) | hold_fire;
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    code_d      = code_q;
    test_mode_d = test_mode_q;
    tmo_d       = 1'b0;
    clr_feed    = 1'b0;
    clr_heal    = 1'b0;
    clr_change  = 1'b0;
    clr_test    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_test_q || pend_heal || pend_feed || pend_change) begin
          state_d = ST_WAIT_ACK;
          tmr_d   = ACK_LOAD;
          if (pend_test_q) begin
            clr_test = 1'b1;
            code_d   = test_code(test_mode_q);
          end else if (pend_heal) begin
            clr_heal = 1'b1;
            code_d   = ACT_HEAL;
          end else if (pend_feed) begin
            clr_feed = 1'b1;
            code_d   = ACT_FEED;
          end else begin
            clr_change = 1'b1;
            code_d     = ACT_CHANGE;
          end
        end
      end

      ST_WAIT_ACK: begin
        if (act_if.action_ack) begin
          state_d = ST_COOLDOWN;
          tmr_d   = COOL_LOAD;
          code_d  = ACT_NONE;
          if (is_test_code(code_q)) begin
            test_mode_d = ~test_mode_q;
          end
        end else if (tmr_q == '0) begin
          // Action dropped; the pulse lands in the first cooldown cycle.
          state_d = ST_COOLDOWN;
          tmr_d   = COOL_LOAD;
          code_d  = ACT_NONE;
          tmo_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end

      ST_COOLDOWN: begin
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
        code_d  = ACT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      code_q       <= ACT_NONE;
      test_mode_q  <= 1'b0;
      tmo_q        <= 1'b0;
      hold_cnt_q   <= '0;
      hold_fired_q <= 1'b0;
      pend_test_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      code_q       <= code_d;
      test_mode_q  <= test_mode_d;
      tmo_q        <= tmo_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_fired_q <= hold_fired_d;
      pend_test_q  <= pend_test_d;
    end
  end

  assign act_if.action_valid = (state_q == ST_WAIT_ACK);
  assign act_if.action_code  = code_q;
  assign test_mode           = test_mode_q;
  assign ack_timeout         = tmo_q;
  assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pet_action_scheduler.sv
module tb_pet_action_scheduler;
  import pet_action_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic feeding = 1'b0;
  logic healing = 1'b0;
  logic change = 1'b0;
  logic test_sig = 1'b0;
  logic test_mode;
  logic ack_timeout;
  logic busy;

  int checks = 0;
  int failures = 0;

  pet_action_scheduler_if act_if ();

  pet_action_scheduler #(
    .HOLD_CYCLES     (8),
    .COOLDOWN_CYCLES (4),
    .ACK_TIMEOUT     (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .feeding     (feeding),
    .healing     (healing),
    .change      (change),
    .test_sig    (test_sig),
    .act_if      (act_if),
    .test_mode   (test_mode),
    .ack_timeout (ack_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Each tick lands 1 ns after a rising edge: outputs are sampled there and
  // inputs set there are captured by the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called in a cycle where valid must be high; acks it and walks through
  // the cooldown, returning in the first IDLE cycle afterwards.
  task automatic serve(input logic [2:0] code, input string tag);
    chk1({tag, "_valid"}, act_if.action_valid, 1'b1);
    chk3({tag, "_code"}, act_if.action_code, code);
    act_if.action_ack = 1'b1;
    tick();
    act_if.action_ack = 1'b0;
    chk1({tag, "_valid_drop"}, act_if.action_valid, 1'b0);
    chk1({tag, "_cool_busy"}, busy, 1'b1);
    tick();
    tick();
    tick();
    chk1({tag, "_cool_last_busy"}, busy, 1'b1);
    tick();
    chk1({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    act_if.action_ack = 1'b0;

    // reset values
    tick();
    tick();
    chk1("rst_valid", act_if.action_valid, 1'b0);
    chk3("rst_code", act_if.action_code, ACT_NONE);
    chk1("rst_test_mode", test_mode, 1'b0);
    chk1("rst_timeout", ack_timeout, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b1;
    tick();

    // single feed, ack three cycles after valid
    feeding = 1'b1;
    tick();
    chk1("feed_grant_cycle_valid", act_if.action_valid, 1'b0);
    tick();
    chk1("feed_valid_n2", act_if.action_valid, 1'b1);
    feeding = 1'b0;
    tick();
    tick();
    tick();
    serve(ACT_FEED, "feed");

    // heal, feed, change together: priority order HEAL, FEED, CHANGE
    healing = 1'b1;
    feeding = 1'b1;
    change  = 1'b1;
    tick();
    healing = 1'b0;
    feeding = 1'b0;
    change  = 1'b0;
    tick();
    serve(ACT_HEAL, "prio1");
    tick();
    serve(ACT_FEED, "prio2");
    tick();
    serve(ACT_CHANGE, "prio3");
    tick();
    chk1("prio_done_busy", busy, 1'b0);

    // short test press: nothing happens
    test_sig = 1'b1;
    repeat (5) tick();
    test_sig = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("short_test_busy", busy, 1'b0);
    end

    // long press: TEST_ON once
    test_sig = 1'b1;
    repeat (8) tick();
    chk1("test_on_before_valid", act_if.action_valid, 1'b0);
    tick();
    serve(ACT_TEST_ON, "test_on");
    chk1("test_mode_on", test_mode, 1'b1);
    repeat (6) tick();
    test_sig = 1'b0;
    chk1("test_on_no_refire", busy, 1'b0);
    repeat (3) tick();
    chk1("test_on_after_release", busy, 1'b0);

    // second long press: TEST_OFF
    test_sig = 1'b1;
    repeat (9) tick();
    serve(ACT_TEST_OFF, "test_off");
    chk1("test_mode_off", test_mode, 1'b0);
    repeat (6) tick();
    test_sig = 1'b0;
    chk1("test_off_no_refire", busy, 1'b0);
    repeat (3) tick();

    // timeout, with a second feed press served afterwards
    feeding = 1'b1;
    tick();
    feeding = 1'b0;
    tick();
    chk1("tmo_valid_first", act_if.action_valid, 1'b1);
    chk3("tmo_code", act_if.action_code, ACT_FEED);
    tick();
    tick();
    feeding = 1'b1;
    tick();
    feeding = 1'b0;
    tick();
    tick();
    chk1("tmo_valid_last", act_if.action_valid, 1'b1);
    chk1("tmo_no_pulse_yet", ack_timeout, 1'b0);
    tick();
    chk1("tmo_valid_drop", act_if.action_valid, 1'b0);
    chk1("tmo_pulse", ack_timeout, 1'b1);
    chk1("tmo_cool_busy", busy, 1'b1);
    tick();
    chk1("tmo_pulse_end", ack_timeout, 1'b0);
    tick();
    tick();
    chk1("tmo_cool_last", busy, 1'b1);
    tick();
    chk1("tmo_idle", busy, 1'b0);
    tick();
    serve(ACT_FEED, "tmo_second");

    // two feed presses during a heal's WAIT_ACK merge into one FEED
    healing = 1'b1;
    tick();
    healing = 1'b0;
    tick();
    chk3("merge_heal_code", act_if.action_code, ACT_HEAL);
    tick();
    feeding = 1'b1;
    tick();
    feeding = 1'b0;
    tick();
    feeding = 1'b1;
    tick();
    feeding = 1'b0;
    serve(ACT_HEAL, "merge_heal");
    tick();
    serve(ACT_FEED, "merge_feed");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("merge_single_feed", busy, 1'b0);
    end

    // reset during WAIT_ACK with change pending
    healing = 1'b1;
    change  = 1'b1;
    tick();
    healing = 1'b0;
    change  = 1'b0;
    tick();
    chk3("rstw_heal_code", act_if.action_code, ACT_HEAL);
    tick();
    rst = 1'b0;
    tick();
    chk1("rstw_valid", act_if.action_valid, 1'b0);
    chk3("rstw_code", act_if.action_code, ACT_NONE);
    chk1("rstw_timeout", ack_timeout, 1'b0);
    chk1("rstw_busy", busy, 1'b0);
    chk1("rstw_test_mode", test_mode, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      act_if.action_ack = (i == 3);
      chk1("rstw_no_action", busy, 1'b0);
      chk1("rstw_no_timeout", ack_timeout, 1'b0);
    end
    act_if.action_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
